// File: rtl/iram_loader.sv
// Instruction-memory responder: loads a program from a host byte stream, then
// serves registered instruction fetches to the core until it signals end of run.
module iram_loader #(
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] host_data,
   input  logic              host_valid,
   input  logic              host_last,
   output logic              host_ready,
   input  logic              restart,
   input  logic              read_IRAM,
   input  logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] iram_out,
   input  logic              end_process,
   output logic              status,
   output logic              done,
   output logic [ADDR_W:0]   prog_len,
   output logic              ovf
);

   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wptr;
   logic              accept_c;
   logic              ovf_c;
   logic              fetch_c;
   logic              clear_c;
   logic              at_top_c;
   logic              in_range_c;

   logic [DATA_W-1:0] mem [DEPTH];

   assign at_top_c   = (wptr == ADDR_W'(DEPTH - 1));
   assign in_range_c = (LEN_W'(pc_out) < prog_len);

   // Next-state and per-cycle action decode.
   always_comb begin
      state_nxt = state;
      accept_c  = 1'b0;
      ovf_c     = 1'b0;
      fetch_c   = 1'b0;
      clear_c   = 1'b0;
      case (state)
         S_LOAD: begin
            if (host_valid) begin
               accept_c = 1'b1;
               ovf_c    = at_top_c && !host_last;
               if (host_last || at_top_c) state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            fetch_c = read_IRAM;
            if (end_process) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (restart) begin
               clear_c   = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // State, control outputs and fetch register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_LOAD;
         host_ready <= 1'b1;
         status     <= 1'b0;
         done       <= 1'b0;
         ovf        <= 1'b0;
         prog_len   <= '0;
         wptr       <= '0;
         iram_out   <= '0;
      end else begin
         state      <= state_nxt;
         host_ready <= (state_nxt == S_LOAD);
         status     <= (state_nxt == S_RUN);
         done       <= (state_nxt == S_DONE);
         if (accept_c) begin
            wptr     <= wptr + ADDR_W'(1);
            prog_len <= LEN_W'(wptr) + LEN_W'(1);
         end
         if (ovf_c) ovf <= 1'b1;
         if (clear_c) begin
            wptr     <= '0;
            prog_len <= '0;
            ovf      <= 1'b0;
         end
         if (fetch_c) iram_out <= in_range_c ? mem[pc_out] : '0;
      end
   end

   // Program storage; contents deliberately survive reset and restart.
   always_ff @(posedge clk) begin
      if (accept_c) mem[wptr] <= host_data;
   end

endmodule

// File: tb/tb_iram_loader.sv
// Directed self-checking bench for iram_loader: load, fetch, end, restart,
// overflow and asynchronous reset scenarios with hand-computed expectations.
module tb_iram_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] host_data;
   logic       host_valid;
   logic       host_last;
   logic       host_ready;
   logic       restart;
   logic       read_IRAM;
   logic [7:0] pc_out;
   logic [7:0] iram_out;
   logic       end_process;
   logic       status;
   logic       done;
   logic [8:0] prog_len;
   logic       ovf;

   int checks   = 0;
   int failures = 0;

   iram_loader dut (
      .clk        (clk),
      .rst        (rst),
      .host_data  (host_data),
      .host_valid (host_valid),
      .host_last  (host_last),
      .host_ready (host_ready),
      .restart    (restart),
      .read_IRAM  (read_IRAM),
      .pc_out     (pc_out),
      .iram_out   (iram_out),
      .end_process(end_process),
      .status     (status),
      .done       (done),
      .prog_len   (prog_len),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_host_ready"}, 32'(host_ready), 32'd1);
      check({tag, "_status"},     32'(status),     32'd0);
      check({tag, "_done"},       32'(done),       32'd0);
      check({tag, "_ovf"},        32'(ovf),        32'd0);
      check({tag, "_prog_len"},   32'(prog_len),   32'd0);
      check({tag, "_iram_out"},   32'(iram_out),   32'd0);
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      host_valid = 1'b1;
      host_data  = d;
      host_last  = last;
      tick();
      host_valid = 1'b0;
      host_last  = 1'b0;
   endtask

   task automatic fetch(input logic [7:0] pc);
      read_IRAM = 1'b1;
      pc_out    = pc;
      tick();
      read_IRAM = 1'b0;
   endtask

   initial begin
      rst = 1'b1; host_data = '0; host_valid = 1'b0; host_last = 1'b0;
      restart = 1'b0; read_IRAM = 1'b0; pc_out = '0; end_process = 1'b0;
      #22;
      check_reset_vals("por");
      rst = 1'b0;
      tick();

      // Three-byte program
      send(8'h04, 1'b0);
      send(8'h08, 1'b0);
      check("pre_last_status", 32'(status), 32'd0);
      check("pre_last_len", 32'(prog_len), 32'd2);
      send(8'h0B, 1'b1);
      check("load3_len", 32'(prog_len), 32'd3);
      check("load3_status", 32'(status), 32'd1);
      check("load3_ready", 32'(host_ready), 32'd0);
      check("load3_ovf", 32'(ovf), 32'd0);

      // Back-to-back fetches
      read_IRAM = 1'b1;
      pc_out = 8'd0; tick(); check("fetch0", 32'(iram_out), 32'h04);
      pc_out = 8'd1; tick(); check("fetch1", 32'(iram_out), 32'h08);
      pc_out = 8'd2; tick(); check("fetch2", 32'(iram_out), 32'h0B);
      pc_out = 8'd3; tick(); check("fetch3_oob", 32'(iram_out), 32'h00);
      read_IRAM = 1'b0; pc_out = 8'd0;
      tick(); check("fetch_hold", 32'(iram_out), 32'h00);

      // End with concurrent fetch
      end_process = 1'b1; read_IRAM = 1'b1; pc_out = 8'd1;
      tick();
      end_process = 1'b0; read_IRAM = 1'b0;
      check("end_fetch", 32'(iram_out), 32'h08);
      check("end_status", 32'(status), 32'd0);
      check("end_done", 32'(done), 32'd1);
      send(8'h55, 1'b1);
      check("done_ready", 32'(host_ready), 32'd0);
      check("done_len", 32'(prog_len), 32'd3);
      check("done_status", 32'(status), 32'd0);
      fetch(8'd0);
      check("done_hold", 32'(iram_out), 32'h08);

      // Restart and one-byte reload
      restart = 1'b1; tick(); restart = 1'b0;
      check("rs_ready", 32'(host_ready), 32'd1);
      check("rs_done", 32'(done), 32'd0);
      check("rs_len", 32'(prog_len), 32'd0);
      send(8'h14, 1'b1);
      check("reload_len", 32'(prog_len), 32'd1);
      check("reload_ovf", 32'(ovf), 32'd0);
      check("reload_status", 32'(status), 32'd1);
      fetch(8'd1); check("stale_hidden", 32'(iram_out), 32'h00);
      fetch(8'd0); check("reload_fetch0", 32'(iram_out), 32'h14);

      // Overflow: 256 bytes without host_last
      end_process = 1'b1; tick(); end_process = 1'b0;
      restart = 1'b1; tick(); restart = 1'b0;
      for (int i = 0; i < 256; i++) begin
         if (i == 255) check("ovf_pre_status", 32'(status), 32'd0);
         send(8'(i), 1'b0);
      end
      check("ovf_flag", 32'(ovf), 32'd1);
      check("ovf_len", 32'(prog_len), 32'd256);
      check("ovf_status", 32'(status), 32'd1);
      check("ovf_ready", 32'(host_ready), 32'd0);
      fetch(8'd255); check("ovf_fetch255", 32'(iram_out), 32'hFF);
      fetch(8'd128); check("ovf_fetch128", 32'(iram_out), 32'h80);

      // Asynchronous reset mid-load
      end_process = 1'b1; tick(); end_process = 1'b0;
      restart = 1'b1; tick(); restart = 1'b0;
      send(8'hA1, 1'b0);
      send(8'hA2, 1'b0);
      check("midload_len", 32'(prog_len), 32'd2);
      #2 rst = 1'b1;
      #1 check_reset_vals("rst_load");
      rst = 1'b0;
      tick();

      // Asynchronous reset mid-run
      send(8'h31, 1'b0);
      send(8'h32, 1'b1);
      fetch(8'd1); check("prerst_fetch", 32'(iram_out), 32'h32);
      #2 rst = 1'b1;
      #1 check_reset_vals("rst_run");
      rst = 1'b0;
      tick();

      send(8'h3C, 1'b1);
      check("post_rst_len", 32'(prog_len), 32'd1);
      fetch(8'd0); check("post_rst_fetch0", 32'(iram_out), 32'h3C);
      fetch(8'd1); check("post_rst_fetch1", 32'(iram_out), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
